// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, datapath
// select codes, ALU operation codes, opcodes and the immediate-format decode.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Immediate format depends only on the opcode; unknown opcodes use I.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_ctrl_dec.sv
// ALU decoder: turns the FSM's coarse ALUOp plus instruction fields into
// the concrete ALU operation.
module alu_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    // Subtract only for R-type funct3=000 with bit 30 set; addi never subtracts.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a multicycle RISC-V subset datapath
// (lw, sw, R-type, I-type ALU, beq, jal) with memory-ready stalls.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    // State register; reset wins over any stall and returns to FETCH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode, everything defaults to 0.
    always_comb begin
        state_d       = state_q;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                state_d      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (alu_control)
    );

    // Strobes are held low during reset so nothing is written while it is asserted.
    assign pc_write   = reset_n & (pc_update | (branch & zero));
    assign ir_write   = reset_n & ir_write_raw;
    assign mem_write  = reset_n & mem_write_raw;
    assign reg_write  = reset_n & reg_write_raw;
    assign illegal_op = reset_n & illegal_raw;
    assign imm_src    = imm_src_for(op);
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instructions plus random
// instruction streams with random memory stalls, checked cycle by cycle
// against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    int stepQ[$];

    logic [16:0] ctrlVec;
    logic [4:0]  strobeVec;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] ITYPE = 7'b0010011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_write   (reg_write),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ctrlVec = {pc_write, adr_src, mem_write, ir_write, result_src,
                      alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal_op};
    assign strobeVec = {pc_write, ir_write, mem_write, reg_write, illegal_op};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic z, input logic rstn);
        mem_ready = mr;
        zero      = z;
        reset_n   = rstn;
    endtask

    function automatic logic [2:0] refAlu(input logic [1:0] aluOp, input logic [6:0] opI,
                                          input logic [2:0] f3, input logic f7);
        if (aluOp == 2'd0) return 3'b000;
        if (aluOp == 2'd1) return 3'b001;
        case (f3)
            3'b000:  return (f7 && opI[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] refImm(input logic [6:0] opI);
        if (opI == SW)  return 2'b01;
        if (opI == BEQ) return 2'b10;
        if (opI == JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Expected control word for one cycle, from the per-step output table.
    function automatic logic [16:0] refCtrl(input int st, input logic [6:0] opI, input logic [2:0] f3,
                                            input logic f7, input logic z, input logic mr, input logic rstn);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b, aop;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; a = 0; b = 0; aop = 0;
        case (st)
            0:  begin b = 2; rs = 2; irw = mr; pcw = mr; end
            1:  begin a = 1; b = 1;
                      ill = !(opI inside {LW, SW, RTYPE, ITYPE, BEQ, JAL}); end
            2:  begin a = 2; b = 1; end
            3:  begin adr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2; aop = 2; end
            7:  begin a = 2; b = 1; aop = 2; end
            8:  begin rw = 1; end
            9:  begin a = 2; aop = 1; pcw = z; end
            10: begin a = 1; b = 2; pcw = 1; end
            default: ;
        endcase
        if (!rstn) begin
            pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0;
        end
        return {pcw, adr, mw, irw, rs, a, b, refAlu(aop, opI, f3, f7), refImm(opI), rw, ill};
    endfunction

    // Sequence of steps an instruction walks through, before any stalls.
    task automatic buildSteps(input logic [6:0] opI);
        stepQ = {};
        case (opI)
            LW:      stepQ = {0, 1, 2, 3, 4};
            SW:      stepQ = {0, 1, 2, 5};
            RTYPE:   stepQ = {0, 1, 6, 8};
            ITYPE:   stepQ = {0, 1, 7, 8};
            BEQ:     stepQ = {0, 1, 9};
            JAL:     stepQ = {0, 1, 10, 8};
            default: stepQ = {0, 1};
        endcase
    endtask

    // Runs one instruction; stallCycles>=0 gives that many low mem_ready
    // cycles at every memory wait, negative means random stalls.
    task automatic runInstr(input logic [6:0] opI, input logic [2:0] f3I, input logic f7I,
                            input logic zeroI, input int stallCycles);
        int idx, cycles, lowLeft, st;
        logic waits, mr, z;
        buildSteps(opI);
        idx = 0; cycles = 0; lowLeft = stallCycles;
        op = opI; funct3 = f3I; funct7b5 = f7I;
        while (idx < stepQ.size()) begin
            if (cycles >= 64) begin
                checkOutput("cycleBudget", 32'd1, 32'd0);
                break;
            end
            st = stepQ[idx];
            waits = (st == 0 || st == 3 || st == 5);
            if (waits) mr = (stallCycles >= 0) ? (lowLeft == 0) : ($urandom_range(0, 99) >= 30);
            else       mr = 1'($urandom_range(0, 1));
            z = (st == 9) ? zeroI : 1'($urandom_range(0, 1));
            applyStimulus(mr, z, 1'b1);
            #3;
            checkOutput($sformatf("state(op=%b step=%0d)", opI, st), 32'(state), 32'(st));
            checkOutput($sformatf("ctrl(op=%b step=%0d)", opI, st), 32'(ctrlVec),
                        32'(refCtrl(st, opI, f3I, f7I, z, mr, 1'b1)));
            @(posedge clk); #1;
            if (waits && !mr) lowLeft--;
            else begin
                idx++;
                lowLeft = stallCycles;
            end
            cycles++;
        end
    endtask

    initial begin
        logic [6:0] rop;
        op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Reset held low with mem_ready high: strobes must stay quiet.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checkOutput("resetState", 32'(state), 32'd0);
            checkOutput("resetStrobes", 32'(strobeVec), 32'd0);
            @(posedge clk); #1;
        end

        // First cycle after reset with memory not ready.
        applyStimulus(1'b0, 1'b0, 1'b1);
        #3;
        checkOutput("postResetState", 32'(state), 32'd0);
        checkOutput("postResetCtrl", 32'(ctrlVec), 32'(refCtrl(0, op, funct3, funct7b5, 1'b0, 1'b0, 1'b1)));
        @(posedge clk); #1;

        // Directed instructions.
        runInstr(LW, 3'b010, 1'b0, 1'b0, 0);
        runInstr(SW, 3'b010, 1'b0, 1'b0, 2);
        runInstr(RTYPE, 3'b000, 1'b1, 1'b0, 0);
        runInstr(ITYPE, 3'b000, 1'b1, 1'b0, 0);
        runInstr(RTYPE, 3'b010, 1'b0, 1'b0, 0);
        runInstr(RTYPE, 3'b110, 1'b0, 1'b0, 0);
        runInstr(RTYPE, 3'b111, 1'b0, 1'b0, 1);
        runInstr(BEQ, 3'b000, 1'b0, 1'b1, 0);
        runInstr(BEQ, 3'b000, 1'b0, 1'b0, 0);
        runInstr(JAL, 3'b000, 1'b0, 1'b0, 0);
        runInstr(7'b1111111, 3'b000, 1'b0, 1'b0, 0);
        runInstr(LW, 3'b000, 1'b0, 1'b0, 3);

        // Random instruction stream with random stalls.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: rop = LW;
                1: rop = SW;
                2: rop = RTYPE;
                3: rop = ITYPE;
                4: rop = BEQ;
                5: rop = JAL;
                default: rop = 7'($urandom_range(0, 127));
            endcase
            runInstr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), -1);
        end

        // Reset while stalled in the load's memory-read step.
        op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #3;
            checkOutput("stallMemread", 32'(state), 32'd3);
            @(posedge clk); #1;
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        #3;
        checkOutput("rstInMemreadStrobes", 32'(strobeVec), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            #3;
            checkOutput("rstFromMemreadState", 32'(state), 32'd0);
            checkOutput("rstFromMemreadStrobes", 32'(strobeVec), 32'd0);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        #3;
        checkOutput("releaseState", 32'(state), 32'd0);
        checkOutput("releaseCtrl", 32'(ctrlVec), 32'(refCtrl(0, op, funct3, funct7b5, 1'b0, 1'b0, 1'b1)));
        @(posedge clk); #1;
        runInstr(LW, 3'b000, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset: clk, reset_n.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- op  in  7  instruction opcode from the instruction register
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 PC, 1 result
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register and OldPC enable
- result_src  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 RegA
- alu_src_b  out  2  ALU B select: 00 RegB, 01 ImmExt, 10 constant 4
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register file write strobe
- illegal_op  out  1  one-cycle pulse for an unsupported opcode
- state  out  4  current FSM state, for debug

Function
REQ-003 SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
REQ-004 Every control output not listed for a state SHALL be 0 in that state.
REQ-005 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10.
- ir_write=mem_ready and pc_update=mem_ready.
- Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-006 DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00 (branch target).
- Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
- Any other op -> FETCH, with illegal_op=1 for that cycle only.
REQ-007 MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00; next state is MEMREAD if op=0000011, else MEMWRITE.
REQ-008 MEMREAD: adr_src=1, result_src=00; hold until mem_ready=1, then go to MEMWB.
REQ-009 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-010 MEMWRITE: adr_src=1, result_src=00, mem_write=1; mem_write stays high until mem_ready=1, then go to FETCH.
REQ-011 EXECUTER: alu_src_a=10, alu_src_b=00, ALUOp=10; next state ALUWB.
REQ-012 EXECUTEI: alu_src_a=10, alu_src_b=01, ALUOp=10; next state ALUWB.
REQ-013 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-014 BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, branch=1; next state FETCH.
REQ-015 JAL: alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, pc_update=1; next state ALUWB.
REQ-016 pc_write SHALL equal pc_update OR (branch AND zero).
REQ-017 imm_src SHALL be combinational from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, any other op 00.
REQ-018 alu_control SHALL be decoded as follows:
- ALUOp 00 -> add; ALUOp 01 -> sub.
- ALUOp 10 with funct3 000 -> sub if (funct7b5 AND op[5]), else add.
- ALUOp 10 with funct3 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-019 Latency SHALL be, with mem_ready=1 throughout: lw 5 cycles; sw 4; R-type and I-type 4; beq 3; jal 4. Each cycle mem_ready is low adds one cycle.

Reset
REQ-020 When reset_n=0 at a clock edge, the state SHALL become FETCH at that edge, regardless of the current state, including a stalled MEMREAD or MEMWRITE.
REQ-021 While reset_n=0, pc_write, ir_write, mem_write, reg_write and illegal_op SHALL be forced to 0.
REQ-022 In the first cycle after reset_n goes high, state SHALL be 0 and all strobes SHALL be 0 until mem_ready is sampled.

Structure
REQ-023 A shared package SHALL hold:
- the state encodings;
- the ALUOp, alu_control, result_src, alu_src_a, alu_src_b and imm_src codes;
- the opcode constants.
REQ-024 The ALU decode SHALL be a separate sub-module, alu_ctrl_dec (inputs ALUOp, funct3, funct7b5, op5; output alu_control). The FSM and imm_src decode stay in multicycle_ctrl.

Verification
REQ-025 lw (op=0000011), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 only in state 4; ir_write=1 and pc_write=1 in cycle 1.
REQ-026 sw, with mem_ready=0 for 2 cycles in MEMWRITE -> mem_write high for 3 consecutive cycles with adr_src=1, then state 0.
REQ-027 R-type sub (op=0110011, funct3=000, funct7b5=1) -> alu_control=001 in EXECUTER. Same fields with op=0010011 (addi) -> alu_control=000.
REQ-028 beq with zero=1 -> pc_write=1 in BEQ. Same with zero=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
REQ-029 op=1111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, no reg_write or mem_write.
REQ-030 reset_n=0 asserted while stalled in MEMREAD -> state=0 at the next edge; all strobes stay 0 while reset_n=0.
